// File: rtl/ika9958_vram_arbiter_if.sv
// Bus bundle between the IKA9958 VRAM arbiter and its requesters/DRAM pins.
// The slave modport is the arbiter side; the master modport is the surrounding core or bench.
interface ika9958_vram_arbiter_if;
  localparam int unsigned AW  = 17;
  localparam int unsigned DW  = 8;
  localparam int unsigned MAW = 9;

  logic           i_XTAL_NCEN;
  logic           i_SLOT_START;
  logic [1:0]     i_SLOT_TYPE;

  logic [AW-1:0]  i_DISP_ADDR;
  logic           o_DISP_VALID;
  logic [DW-1:0]  o_DISP_RDATA;

  logic           i_CPU_REQ;
  logic           i_CPU_WR;
  logic [AW-1:0]  i_CPU_ADDR;
  logic [DW-1:0]  i_CPU_WDATA;
  logic           o_CPU_ACK;
  logic [DW-1:0]  o_CPU_RDATA;

  logic           i_CMD_REQ;
  logic           i_CMD_WR;
  logic [AW-1:0]  i_CMD_ADDR;
  logic [DW-1:0]  i_CMD_WDATA;
  logic           o_CMD_ACK;
  logic [DW-1:0]  o_CMD_RDATA;

  logic           o_RAS_n;
  logic           o_CAS_n;
  logic           o_WE_n;
  logic [MAW-1:0] o_MA;
  logic [DW-1:0]  o_MD_OUT;
  logic           o_MD_OE;
  logic [DW-1:0]  i_MD_IN;

  modport slave (
    input  i_XTAL_NCEN, i_SLOT_START, i_SLOT_TYPE,
    input  i_DISP_ADDR,
    output o_DISP_VALID, o_DISP_RDATA,
    input  i_CPU_REQ, i_CPU_WR, i_CPU_ADDR, i_CPU_WDATA,
    output o_CPU_ACK, o_CPU_RDATA,
    input  i_CMD_REQ, i_CMD_WR, i_CMD_ADDR, i_CMD_WDATA,
    output o_CMD_ACK, o_CMD_RDATA,
    output o_RAS_n, o_CAS_n, o_WE_n, o_MA, o_MD_OUT, o_MD_OE,
    input  i_MD_IN
  );

  modport master (
    output i_XTAL_NCEN, i_SLOT_START, i_SLOT_TYPE,
    output i_DISP_ADDR,
    input  o_DISP_VALID, o_DISP_RDATA,
    output i_CPU_REQ, i_CPU_WR, i_CPU_ADDR, i_CPU_WDATA,
    input  o_CPU_ACK, o_CPU_RDATA,
    output i_CMD_REQ, i_CMD_WR, i_CMD_ADDR, i_CMD_WDATA,
    input  o_CMD_ACK, o_CMD_RDATA,
    input  o_RAS_n, o_CAS_n, o_WE_n, o_MA, o_MD_OUT, o_MD_OE,
    output i_MD_IN
  );
endinterface

// File: rtl/ika9958_vram_arbiter.sv
// IKA9958 VRAM slot arbiter: grants each access slot and runs the four-phase DRAM strobe sequence.
// Define IKA9958_VRAM_REFRESH_EN to enable RAS-only refresh slots; otherwise refresh slots act as idle.
module ika9958_vram_arbiter #(
  parameter int unsigned CMD_STARVE_LIMIT = 3
) (
  input  logic                        i_XTAL1,
  input  logic                        i_RST_n,
  ika9958_vram_arbiter_if.slave       bus
);

  localparam int unsigned AW  = 17;
  localparam int unsigned DW  = 8;
  localparam int unsigned MAW = 9;
  localparam int unsigned CW  = 8;
  localparam int unsigned SW  = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PH0  = 3'd1;
  localparam logic [2:0] ST_PH1  = 3'd2;
  localparam logic [2:0] ST_PH2  = 3'd3;
  localparam logic [2:0] ST_PH3  = 3'd4;

  localparam logic [2:0] OWN_NONE = 3'd0;
  localparam logic [2:0] OWN_DISP = 3'd1;
  localparam logic [2:0] OWN_CPU  = 3'd2;
  localparam logic [2:0] OWN_CMD  = 3'd3;
  localparam logic [2:0] OWN_REF  = 3'd4;

  localparam logic [1:0] SLOT_DISP = 2'd0;
  localparam logic [1:0] SLOT_FREE = 2'd1;
  localparam logic [1:0] SLOT_REF  = 2'd2;
  localparam logic [1:0] SLOT_IDLE = 2'd3;

  localparam logic [SW-1:0] STARVE_LIMIT = SW'(CMD_STARVE_LIMIT);

  logic [2:0]     state_q,      state_d;
  logic [2:0]     owner_q,      owner_d;
  logic [CW-1:0]  col_q,        col_d;
  logic           wr_q,         wr_d;
  logic [DW-1:0]  wdata_q,      wdata_d;
  logic [SW-1:0]  skip_q,       skip_d;
  logic [SW-1:0]  skip_pend_q,  skip_pend_d;
  logic           ras_n_q,      ras_n_d;
  logic           cas_n_q,      cas_n_d;
  logic           we_n_q,       we_n_d;
  logic [MAW-1:0] ma_q,         ma_d;
  logic [DW-1:0]  md_out_q,     md_out_d;
  logic           md_oe_q,      md_oe_d;
  logic           disp_valid_q, disp_valid_d;
  logic [DW-1:0]  disp_rdata_q, disp_rdata_d;
  logic           cpu_ack_q,    cpu_ack_d;
  logic [DW-1:0]  cpu_rdata_q,  cpu_rdata_d;
  logic           cmd_ack_q,    cmd_ack_d;
  logic [DW-1:0]  cmd_rdata_q,  cmd_rdata_d;
`ifdef IKA9958_VRAM_REFRESH_EN
  logic [MAW-1:0] refcnt_q,     refcnt_d;
`endif

  logic           tick;
  logic           completing;
  logic           cpu_req_eff;
  logic           cmd_req_eff;
  logic [SW-1:0]  skip_eff;

  assign tick       = bus.i_XTAL_NCEN;
  assign completing = tick && (state_q == ST_PH3);

  // A requester being acked (or acked last cycle) still shows a stale REQ; never re-grant it.
  assign cpu_req_eff = bus.i_CPU_REQ && !cpu_ack_q && !(completing && (owner_q == OWN_CPU));
  assign cmd_req_eff = bus.i_CMD_REQ && !cmd_ack_q && !(completing && (owner_q == OWN_CMD));

  // Next-state, slot ownership and strobe sequencing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    col_d        = col_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    skip_d       = skip_q;
    skip_pend_d  = skip_pend_q;
    ras_n_d      = ras_n_q;
    cas_n_d      = cas_n_q;
    we_n_d       = we_n_q;
    ma_d         = ma_q;
    md_out_d     = md_out_q;
    md_oe_d      = md_oe_q;
    disp_valid_d = 1'b0;
    disp_rdata_d = disp_rdata_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cmd_ack_d    = 1'b0;
    cmd_rdata_d  = cmd_rdata_q;
`ifdef IKA9958_VRAM_REFRESH_EN
    refcnt_d     = refcnt_q;
`endif

    // End of PH3: deliver data, commit slot bookkeeping, release the DRAM
    if (completing) begin
      state_d = ST_IDLE;
      ras_n_d = 1'b1;
      cas_n_d = 1'b1;
      we_n_d  = 1'b1;
      md_oe_d = 1'b0;
      skip_d  = skip_pend_q;
      case (owner_q)
        OWN_DISP: begin
          disp_valid_d = 1'b1;
          if (!wr_q) disp_rdata_d = bus.i_MD_IN;
        end
        OWN_CPU: begin
          cpu_ack_d = 1'b1;
          if (!wr_q) cpu_rdata_d = bus.i_MD_IN;
        end
        OWN_CMD: begin
          cmd_ack_d = 1'b1;
          if (!wr_q) cmd_rdata_d = bus.i_MD_IN;
        end
`ifdef IKA9958_VRAM_REFRESH_EN
        OWN_REF: refcnt_d = refcnt_q + MAW'(1);
`endif
        default: ;
      endcase
    end

    skip_eff = skip_d;

    if (tick && bus.i_SLOT_START) begin
      // New slot (also aborts any slot in flight): strobes high, arbitrate, present row
      state_d     = ST_PH0;
      ras_n_d     = 1'b1;
      cas_n_d     = 1'b1;
      we_n_d      = 1'b1;
      md_oe_d     = 1'b0;
      owner_d     = OWN_NONE;
      wr_d        = 1'b0;
      skip_pend_d = skip_eff;
      case (bus.i_SLOT_TYPE)
        SLOT_DISP: begin
          owner_d = OWN_DISP;
          ma_d    = bus.i_DISP_ADDR[AW-1:CW];
          col_d   = bus.i_DISP_ADDR[CW-1:0];
        end
        SLOT_FREE: begin
          if (cmd_req_eff && (!cpu_req_eff || (skip_eff == STARVE_LIMIT))) begin
            owner_d     = OWN_CMD;
            wr_d        = bus.i_CMD_WR;
            wdata_d     = bus.i_CMD_WDATA;
            ma_d        = bus.i_CMD_ADDR[AW-1:CW];
            col_d       = bus.i_CMD_ADDR[CW-1:0];
            skip_pend_d = '0;
          end else if (cpu_req_eff) begin
            owner_d = OWN_CPU;
            wr_d    = bus.i_CPU_WR;
            wdata_d = bus.i_CPU_WDATA;
            ma_d    = bus.i_CPU_ADDR[AW-1:CW];
            col_d   = bus.i_CPU_ADDR[CW-1:0];
            if (!cmd_req_eff)                 skip_pend_d = '0;
            else if (skip_eff < STARVE_LIMIT) skip_pend_d = skip_eff + SW'(1);
            else                              skip_pend_d = skip_eff;
          end else begin
            skip_pend_d = '0;
          end
        end
        SLOT_REF: begin
`ifdef IKA9958_VRAM_REFRESH_EN
          owner_d = OWN_REF;
          ma_d    = refcnt_d;
`endif
        end
        SLOT_IDLE: ;
        default:   ;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_PH0: begin
          state_d = ST_PH1;
          if (owner_q != OWN_NONE) ras_n_d = 1'b0;
        end
        ST_PH1: begin
          state_d = ST_PH2;
          if ((owner_q != OWN_NONE) && (owner_q != OWN_REF)) begin
            ma_d = {1'b0, col_q};
            if (wr_q) begin
              we_n_d   = 1'b0;
              md_oe_d  = 1'b1;
              md_out_d = wdata_q;
            end
          end
        end
        ST_PH2: begin
          state_d = ST_PH3;
          if ((owner_q != OWN_NONE) && (owner_q != OWN_REF)) cas_n_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset releases the DRAM immediately
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      col_q        <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      skip_q       <= '0;
      skip_pend_q  <= '0;
      ras_n_q      <= 1'b1;
      cas_n_q      <= 1'b1;
      we_n_q       <= 1'b1;
      ma_q         <= '0;
      md_out_q     <= '0;
      md_oe_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cmd_ack_q    <= 1'b0;
      cmd_rdata_q  <= '0;
`ifdef IKA9958_VRAM_REFRESH_EN
      refcnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      col_q        <= col_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      skip_q       <= skip_d;
      skip_pend_q  <= skip_pend_d;
      ras_n_q      <= ras_n_d;
      cas_n_q      <= cas_n_d;
      we_n_q       <= we_n_d;
      ma_q         <= ma_d;
      md_out_q     <= md_out_d;
      md_oe_q      <= md_oe_d;
      disp_valid_q <= disp_valid_d;
      disp_rdata_q <= disp_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cmd_ack_q    <= cmd_ack_d;
      cmd_rdata_q  <= cmd_rdata_d;
`ifdef IKA9958_VRAM_REFRESH_EN
      refcnt_q     <= refcnt_d;
`endif
    end
  end

  assign bus.o_RAS_n      = ras_n_q;
  assign bus.o_CAS_n      = cas_n_q;
  assign bus.o_WE_n       = we_n_q;
  assign bus.o_MA         = ma_q;
  assign bus.o_MD_OUT     = md_out_q;
  assign bus.o_MD_OE      = md_oe_q;
  assign bus.o_DISP_VALID = disp_valid_q;
  assign bus.o_DISP_RDATA = disp_rdata_q;
  assign bus.o_CPU_ACK    = cpu_ack_q;
  assign bus.o_CPU_RDATA  = cpu_rdata_q;
  assign bus.o_CMD_ACK    = cmd_ack_q;
  assign bus.o_CMD_RDATA  = cmd_rdata_q;

endmodule
